// File: rtl/ch_mover.sv
// Per-channel move sequencer: drains the source FIFO into the destination FIFO for a programmed word count.
// Optional stall timeout enabled with `define CH_MOVER_TIMEOUT_EN.
module ch_mover #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned TO_W  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             m_reset,
  output logic             m_src_getn,
  input  logic [63:0]      m_src,
  input  logic             m_src_last,
  input  logic             m_src_empty,
  output logic             m_dst_putn,
  output logic [63:0]      m_dst,
  output logic             m_dst_last,
  input  logic             m_dst_almost_full,
  input  logic             m_dst_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_SHORT = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_get_q, rem_get_d;
  logic [CNT_W-1:0] rem_put_q, rem_put_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [1:0]       status_q, status_d;
  logic             pipe_valid_q, pipe_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             m_reset_q, m_reset_d;
  logic             get_c;
  logic             put_c;

  // Gets are gated combinationally so a pending last word stops further fetches in the same cycle.
  assign get_c = (state_q == S_RUN) && !abort && (rem_get_q != '0) && !m_src_empty &&
                 !m_dst_full && !m_dst_almost_full && !(pipe_valid_q && m_src_last);
  assign put_c = pipe_valid_q;

  assign m_src_getn = !get_c;
  assign m_dst_putn = !put_c;
  assign m_dst      = pipe_valid_q ? m_src : '0;
  assign m_dst_last = pipe_valid_q && ((rem_put_q == CNT_W'(1)) || m_src_last);

`ifdef CH_MOVER_TIMEOUT_EN
  localparam logic [1:0]      ST_TO   = 2'b10;
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stall_c;

  assign stall_c = (state_q == S_RUN) && !get_c && !put_c;

  // Stall counter: counts RUN cycles with no traffic, cleared by any get/put or a start.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_IDLE && start) begin
      to_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      to_cnt_d = stall_c ? to_cnt_q + TO_W'(1) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_to_w_c;
  assign unused_to_w_c = (TO_W == 32'd0);
`endif

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    rem_get_d    = rem_get_q;
    rem_put_d    = rem_put_q;
    xfer_cnt_d   = xfer_cnt_q;
    status_d     = status_q;
    pipe_valid_d = get_c;

    if (get_c) begin
      rem_get_d = rem_get_q - CNT_W'(1);
    end
    if (put_c) begin
      if (rem_put_q != '0) begin
        rem_put_d = rem_put_q - CNT_W'(1);
      end
      if (xfer_cnt_q != {CNT_W{1'b1}}) begin
        xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xfer_cnt_d = '0;
          status_d   = ST_OK;
          if (dc == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RUN;
            rem_get_d = dc;
            rem_put_d = dc;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_ABORT;
          status_d = ST_ABORT;
        end else if (put_c && rem_put_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (put_c && m_src_last) begin
          state_d  = S_DONE;
          status_d = ST_SHORT;
        end
`ifdef CH_MOVER_TIMEOUT_EN
        else if (stall_c && to_cnt_q == TO_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TO;
        end
`endif
      end
      S_ABORT: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d == S_RUN) || (state_d == S_ABORT);
    done_d    = (state_d == S_DONE);
    m_reset_d = (state_d == S_ABORT);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= S_IDLE;
      rem_get_q    <= '0;
      rem_put_q    <= '0;
      xfer_cnt_q   <= '0;
      status_q     <= ST_OK;
      pipe_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      m_reset_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_get_q    <= rem_get_d;
      rem_put_q    <= rem_put_d;
      xfer_cnt_q   <= xfer_cnt_d;
      status_q     <= status_d;
      pipe_valid_q <= pipe_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      m_reset_q    <= m_reset_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign xfer_cnt = xfer_cnt_q;
  assign m_reset  = m_reset_q;

endmodule

// File: tb/tb_ch_mover.sv
// Directed bench for ch_mover: source FIFO model, destination capture, immediate-assertion checks.
module tb_ch_mover;
  localparam int unsigned CNT_W = 24;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] dc = '0;
  logic             busy, done, m_reset, m_src_getn, m_dst_putn, m_dst_last;
  logic [1:0]       status;
  logic [CNT_W-1:0] xfer_cnt;
  logic [63:0]      m_src = '0;
  logic             m_src_last = 1'b0;
  logic             m_src_empty;
  logic [63:0]      m_dst;
  logic             m_dst_almost_full = 1'b0;
  logic             m_dst_full = 1'b0;

  int checks = 0;
  int errors = 0;

  ch_mover #(.CNT_W(CNT_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort), .dc(dc),
    .busy(busy), .done(done), .status(status), .xfer_cnt(xfer_cnt), .m_reset(m_reset),
    .m_src_getn(m_src_getn), .m_src(m_src), .m_src_last(m_src_last), .m_src_empty(m_src_empty),
    .m_dst_putn(m_dst_putn), .m_dst(m_dst), .m_dst_last(m_dst_last),
    .m_dst_almost_full(m_dst_almost_full), .m_dst_full(m_dst_full)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Source FIFO model with a one-cycle read latency.
  logic [63:0] src_mem [0:15];
  logic        src_lst [0:15];
  int          src_wr = 0;
  int          src_rd = 0;
  logic        src_clr = 1'b0;
  assign m_src_empty = (src_rd >= src_wr);

  always @(posedge wb_clk_i) begin
    if (src_clr) begin
      src_rd <= 0;
    end else if (m_reset) begin
      src_rd <= src_wr;
    end else if (!m_src_getn && src_rd < src_wr) begin
      m_src      <= src_mem[src_rd];
      m_src_last <= src_lst[src_rd];
      src_rd     <= src_rd + 1;
    end
  end

  // Destination capture and event counters.
  logic [63:0] dq_data [$];
  logic        dq_last [$];
  int          put_cyc [$];
  int cyc = 0, get_cnt = 0, put_cnt = 0, mreset_cnt = 0, done_cnt = 0, af_get_cnt = 0;

  always @(posedge wb_clk_i) begin
    cyc <= cyc + 1;
    if (!m_src_getn) get_cnt <= get_cnt + 1;
    if (!m_src_getn && m_dst_almost_full) af_get_cnt <= af_get_cnt + 1;
    if (m_reset) mreset_cnt <= mreset_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!m_dst_putn) begin
      put_cnt <= put_cnt + 1;
      dq_data.push_back(m_dst);
      dq_last.push_back(m_dst_last);
      put_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [63:0] mult, input int last_at);
    for (int i = 0; i < n; i++) begin
      src_mem[i] = mult * 64'(i + 1);
      src_lst[i] = (i == last_at);
    end
    src_wr  = n;
    src_clr = 1'b1;
    @(negedge wb_clk_i);
    src_clr = 1'b0;
  endtask

  task automatic go(input int n);
    dc    = CNT_W'(n);
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge wb_clk_i);
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  int b, g0, p0, m0, d0, a0;
  bit hit;

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_xfer", 64'(xfer_cnt), 64'd0);
    chk("rst_mreset", 64'(m_reset), 64'd0);
    chk("rst_getn", 64'(m_src_getn), 64'd1);
    chk("rst_putn", 64'(m_dst_putn), 64'd1);
    chk("rst_mdst", m_dst, 64'd0);
    chk("rst_mdst_last", 64'(m_dst_last), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);

    // Normal move, late last on the final counted word.
    load(4, 64'h11, 3);
    b = dq_data.size();
    go(4);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 20);
    chk("t1_status", 64'(status), 64'd0);
    chk("t1_xfer", 64'(xfer_cnt), 64'd4);
    chk("t1_nputs", 64'(dq_data.size() - b), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", dq_data[b+i], 64'h11 * 64'(i + 1));
      chk("t1_last", 64'(dq_last[b+i]), 64'(i == 3));
    end
    chk("t1_back_to_back", 64'(put_cyc[b+3] - put_cyc[b]), 64'd3);
    chk("t1_src_empty", 64'(m_src_empty), 64'd1);
    @(negedge wb_clk_i);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Early last: source holds extra words beyond the tagged one.
    load(7, 64'h101, 2);
    b  = dq_data.size();
    g0 = get_cnt;
    go(8);
    wait_done("t2", 20);
    chk("t2_status", 64'(status), 64'd1);
    chk("t2_xfer", 64'(xfer_cnt), 64'd3);
    chk("t2_gets", 64'(get_cnt - g0), 64'd3);
    chk("t2_nputs", 64'(dq_data.size() - b), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", dq_data[b+i], 64'h101 * 64'(i + 1));
      chk("t2_last", 64'(dq_last[b+i]), 64'(i == 2));
    end
    @(negedge wb_clk_i);

    // Zero-length move: done on the cycle after start, no FIFO traffic.
    load(2, 64'h77, 1);
    g0 = get_cnt;
    p0 = put_cnt;
    go(0);
    chk("t4_done_2nd_cycle", 64'(done), 64'd1);
    chk("t4_status", 64'(status), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_xfer", 64'(xfer_cnt), 64'd0);
    @(negedge wb_clk_i);
    chk("t4_done_pulse", 64'(done), 64'd0);
    chk("t4_gets", 64'(get_cnt - g0), 64'd0);
    chk("t4_puts", 64'(put_cnt - p0), 64'd0);

    // Almost-full hold mid-transfer.
    load(6, 64'h1000, 5);
    b  = dq_data.size();
    a0 = af_get_cnt;
    go(6);
    @(negedge wb_clk_i);
    m_dst_almost_full = 1'b1;
    repeat (10) @(negedge wb_clk_i);
    chk("t3_af_gets", 64'(af_get_cnt - a0), 64'd0);
    chk("t3_xfer_hold", 64'(xfer_cnt), 64'd1);
    chk("t3_busy_hold", 64'(busy), 64'd1);
    m_dst_almost_full = 1'b0;
    wait_done("t3", 20);
    chk("t3_status", 64'(status), 64'd0);
    chk("t3_xfer", 64'(xfer_cnt), 64'd6);
    chk("t3_nputs", 64'(dq_data.size() - b), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_data", dq_data[b+i], 64'h1000 * 64'(i + 1));
      chk("t3_last", 64'(dq_last[b+i]), 64'(i == 5));
    end
    @(negedge wb_clk_i);

    // Abort while idle is ignored.
    m0 = mreset_cnt;
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    @(negedge wb_clk_i);
    chk("idle_abort_mreset", 64'(mreset_cnt - m0), 64'd0);
    chk("idle_abort_done", 64'(done_cnt - d0), 64'd0);

    // Abort during the second put.
    load(10, 64'h10000, 9);
    p0 = put_cnt;
    m0 = mreset_cnt;
    go(10);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (put_cnt - p0 == 1 && !m_dst_putn) hit = 1'b1;
      else @(negedge wb_clk_i);
    end
    chk("t5_second_put_seen", 64'(hit), 64'd1);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    chk("t5_mreset", 64'(m_reset), 64'd1);
    @(negedge wb_clk_i);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_status", 64'(status), 64'd3);
    chk("t5_xfer", 64'(xfer_cnt), 64'd2);
    chk("t5_puts", 64'(put_cnt - p0), 64'd2);
    @(negedge wb_clk_i);
    chk("t5_mreset_pulses", 64'(mreset_cnt - m0), 64'd1);

    // Asynchronous reset mid-move.
    load(10, 64'h1, 9);
    go(10);
    repeat (3) @(negedge wb_clk_i);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    chk("t6_putn_pre", 64'(m_dst_putn), 64'd0);
    d0 = done_cnt;
    #2 wb_rst_i = 1'b0;
    #1;
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_getn_rst", 64'(m_src_getn), 64'd1);
    chk("t6_putn_rst", 64'(m_dst_putn), 64'd1);
    chk("t6_xfer_rst", 64'(xfer_cnt), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_status", 64'(status), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
